// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// multiply sequencer states and the hard-wired zero register.
package hazard_pkg;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mult_state_t;

  // A writer in a later stage satisfies a source read; $0 never matches.
  function automatic logic reg_hit(input logic we, input logic [4:0] wa,
                                   input logic [4:0] src);
    return we && (wa != REG_ZERO) && (wa == src);
  endfunction
endpackage

// File: rtl/mult_seq.sv
// Multi-cycle multu sequencer: holds E for MULT_CYCLES-1 cycles per multu and
// pulses mult_doneE in the final occupancy cycle.
module mult_seq
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic multu_startE,
  output logic mul_stall,
  output logic mult_busy,
  output logic mult_doneE
);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mult_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  // Done is registered one cycle ahead so it lines up with BUSY & cnt==0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (multu_startE) begin
            r_state <= BUSY;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_done  <= (CNT_LOAD == '0);
          end else begin
            r_done  <= 1'b0;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - CNT_ONE;
            r_done <= (r_cnt == CNT_ONE);
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign mul_stall  = ((r_state == IDLE) && multu_startE) ||
                      ((r_state == BUSY) && (r_cnt != '0));
  assign mult_busy  = r_busy;
  assign mult_doneE = r_done;
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline.
// Define HAZARD_PERF_EN to add saturating stall/flush/multiply event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] rf_waE,
  input  logic [4:0] rf_waM,
  input  logic [4:0] rf_waW,
  input  logic       we_regE,
  input  logic       we_regM,
  input  logic       we_regW,
  input  logic       dm2regE,
  input  logic       dm2regM,
  input  logic       branchD,
  input  logic       jr_selD,
  input  logic       pc_srcD,
  input  logic       multu_startE,
  output logic [1:0] fwd_aE,
  output logic [1:0] fwd_bE,
  output logic       fwd_aD,
  output logic       fwd_bD,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       mult_busy,
  output logic       mult_doneE
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_mult_cnt
`endif
);
  logic       w_mul_stall;
  logic [1:0] w_fwd_aE;
  logic [1:0] w_fwd_bE;
  logic       w_load_use;
  logic       w_ctrl_use;
  logic       w_use_rs;
  logic       w_use_rt;

  mult_seq #(
    .MULT_CYCLES(MULT_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mult_seq (
    .clk         (clk),
    .rst         (rst),
    .multu_startE(multu_startE),
    .mul_stall   (w_mul_stall),
    .mult_busy   (mult_busy),
    .mult_doneE  (mult_doneE)
  );

  assign w_fwd_aE = reg_hit(we_regM, rf_waM, rsE) ? FWD_M :
                    reg_hit(we_regW, rf_waW, rsE) ? FWD_W : FWD_RF;
  assign w_fwd_bE = reg_hit(we_regM, rf_waM, rtE) ? FWD_M :
                    reg_hit(we_regW, rf_waW, rtE) ? FWD_W : FWD_RF;

  assign fwd_aE = rst ? FWD_RF : w_fwd_aE;
  assign fwd_bE = rst ? FWD_RF : w_fwd_bE;
  assign fwd_aD = !rst && reg_hit(we_regM, rf_waM, rsD);
  assign fwd_bD = !rst && reg_hit(we_regM, rf_waM, rtD);

  assign w_load_use = reg_hit(dm2regE, rf_waE, rsD) || reg_hit(dm2regE, rf_waE, rtD);

  // Branch compares rs and rt; jr only reads rs.
  assign w_use_rs   = branchD || jr_selD;
  assign w_use_rt   = branchD;
  assign w_ctrl_use =
    (w_use_rs && (reg_hit(we_regE, rf_waE, rsD) || reg_hit(dm2regM, rf_waM, rsD))) ||
    (w_use_rt && (reg_hit(we_regE, rf_waE, rtD) || reg_hit(dm2regM, rf_waM, rtD)));

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (rst) begin
      stallF = 1'b0;
    end else if (w_mul_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (w_load_use || w_ctrl_use) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (pc_srcD) begin
      flushD = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_mult;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
      r_perf_mult  <= '0;
    end else begin
      if (stallF && (r_perf_stall != '1))              r_perf_stall <= r_perf_stall + 32'd1;
      if ((flushD || flushE) && (r_perf_flush != '1))  r_perf_flush <= r_perf_flush + 32'd1;
      if (mult_doneE && (r_perf_mult != '1))           r_perf_mult  <= r_perf_mult + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
  assign perf_mult_cnt  = r_perf_mult;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed test-plan vectors then random traffic.
module tb_hazard_ctrl;
  localparam int MC = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, waE, waM, waW;
    logic       weE, weM, weW, dmE, dmM, br, jr, pcs, mst;
  } stim_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rsD = '0, rtD = '0, rsE = '0, rtE = '0;
  logic [4:0] rf_waE = '0, rf_waM = '0, rf_waW = '0;
  logic       we_regE = 0, we_regM = 0, we_regW = 0, dm2regE = 0, dm2regM = 0;
  logic       branchD = 0, jr_selD = 0, pc_srcD = 0, multu_startE = 0;
  logic [1:0] fwd_aE, fwd_bE;
  logic       fwd_aD, fwd_bD, stallF, stallD, stallE, flushD, flushE, flushM;
  logic       mult_busy, mult_doneE;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_mult_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int rem    = 0;
  logic [13:0] expq[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(MC), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .rf_waE(rf_waE), .rf_waM(rf_waM), .rf_waW(rf_waW),
    .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW),
    .dm2regE(dm2regE), .dm2regM(dm2regM), .branchD(branchD), .jr_selD(jr_selD),
    .pc_srcD(pc_srcD), .multu_startE(multu_startE),
    .fwd_aE(fwd_aE), .fwd_bE(fwd_bE), .fwd_aD(fwd_aD), .fwd_bD(fwd_bD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .mult_busy(mult_busy), .mult_doneE(mult_doneE)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_mult_cnt(perf_mult_cnt)
`endif
  );

  function automatic bit hit(input logic we, input logic [4:0] wa, input logic [4:0] src);
    return (we == 1'b1) && (wa != 5'd0) && (wa == src);
  endfunction

  // Reference: rem counts the cycles the current multu still occupies E.
  task automatic apply(input stim_t s);
    logic [1:0] fa, fb;
    bit fad, fbd, sF, sD, sE, fD, fE, fM, busy, done, mstall, lu, cu, used_rs, used_rt;
    @(posedge clk);
    #1;
    rst = s.rst; rsD = s.rsD; rtD = s.rtD; rsE = s.rsE; rtE = s.rtE;
    rf_waE = s.waE; rf_waM = s.waM; rf_waW = s.waW;
    we_regE = s.weE; we_regM = s.weM; we_regW = s.weW;
    dm2regE = s.dmE; dm2regM = s.dmM; branchD = s.br; jr_selD = s.jr;
    pc_srcD = s.pcs; multu_startE = s.mst;
    if (s.rst) begin
      rem = 0;
      expq.push_back(14'd0);
    end else begin
      fa = hit(s.weM, s.waM, s.rsE) ? 2'd2 : hit(s.weW, s.waW, s.rsE) ? 2'd1 : 2'd0;
      fb = hit(s.weM, s.waM, s.rtE) ? 2'd2 : hit(s.weW, s.waW, s.rtE) ? 2'd1 : 2'd0;
      fad = hit(s.weM, s.waM, s.rsD);
      fbd = hit(s.weM, s.waM, s.rtD);
      lu = hit(s.dmE, s.waE, s.rsD) || hit(s.dmE, s.waE, s.rtD);
      used_rs = s.br || s.jr;
      used_rt = s.br;
      cu = (used_rs && (hit(s.weE, s.waE, s.rsD) || hit(s.dmM, s.waM, s.rsD))) ||
           (used_rt && (hit(s.weE, s.waE, s.rtD) || hit(s.dmM, s.waM, s.rtD)));
      mstall = (rem == 0 && s.mst) || (rem > 1);
      done = (rem == 1);
      busy = (rem > 0);
      if (rem == 0 && s.mst) rem = MC - 1;
      else if (rem > 0) rem = rem - 1;
      {sF, sD, sE, fD, fE, fM} = '0;
      if (mstall) begin sF = 1; sD = 1; sE = 1; fM = 1; end
      else if (lu || cu) begin sF = 1; sD = 1; fE = 1; end
      else if (s.pcs) fD = 1;
      expq.push_back({fa, fb, fad, fbd, sF, sD, sE, fD, fE, fM, busy, done});
    end
  endtask

  initial begin : monitor
    logic [13:0] e, a;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a = {fwd_aE, fwd_bE, fwd_aD, fwd_bD, stallF, stallD, stallE,
             flushD, flushE, flushM, mult_busy, mult_doneE};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs @%0t {faE,fbE,faD,fbD,sF,sD,sE,fD,fE,fM,busy,done} got=%b want=%b",
                   $time, a, e);
        end
      end
    end
  end

  initial begin : stim
    stim_t s;
    s = '0; s.rst = 1; apply(s); apply(s);
    // E-stage forwarding priority
    s = '0; s.waM = 5; s.weM = 1; s.rsE = 5; s.waW = 5; s.weW = 1; apply(s);
    s.weM = 0; apply(s);
    s.waM = 0; s.weM = 1; s.rsE = 0; s.waW = 0; apply(s);
    // load-use then forward from M
    s = '0; s.dmE = 1; s.weE = 1; s.waE = 8; s.rtD = 8; apply(s);
    s = '0; s.weM = 1; s.waM = 8; s.rtE = 8; apply(s);
    // branch behind ALU op, then behind a load
    s = '0; s.br = 1; s.rsD = 9; s.weE = 1; s.waE = 9; apply(s);
    s = '0; s.br = 1; s.rsD = 9; s.weM = 1; s.waM = 9; apply(s);
    s = '0; s.br = 1; s.rsD = 9; s.weE = 1; s.dmE = 1; s.waE = 9; apply(s);
    s = '0; s.br = 1; s.rsD = 9; s.weM = 1; s.dmM = 1; s.waM = 9; apply(s);
    s = '0; s.br = 1; s.rsD = 9; s.weW = 1; s.waW = 9; apply(s);
    s = '0; s.jr = 1; s.rtD = 9; s.weE = 1; s.waE = 9; apply(s);
    // back-to-back multu with start held
    s = '0; s.mst = 1;
    for (int i = 0; i < 8; i++) apply(s);
    s.mst = 0; apply(s); apply(s);
    // reset mid-BUSY, then restart
    s = '0; s.mst = 1; apply(s);
    s.mst = 0; apply(s); apply(s);
    s.rst = 1; s.mst = 1; apply(s);
    s.rst = 0;
    for (int i = 0; i < 5; i++) apply(s);
    s.mst = 0; apply(s);
    // redirect coincident with load-use
    s = '0; s.pcs = 1; s.dmE = 1; s.weE = 1; s.waE = 4; s.rsD = 4; apply(s);
    s = '0; s.pcs = 1; apply(s);
    s = '0; apply(s);
    // random traffic over a small register window so matches are frequent
    for (int i = 0; i < 1500; i++) begin
      s.rst = ($urandom_range(0, 99) == 0);
      s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
      s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
      s.waE = 5'($urandom_range(0, 3)); s.waM = 5'($urandom_range(0, 3));
      s.waW = 5'($urandom_range(0, 3));
      s.weE = 1'($urandom); s.weM = 1'($urandom); s.weW = 1'($urandom);
      s.dmE = 1'($urandom); s.dmM = 1'($urandom);
      s.br = 1'($urandom); s.jr = ($urandom_range(0, 3) == 0);
      s.pcs = 1'($urandom); s.mst = ($urandom_range(0, 5) == 0);
      apply(s);
    end
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
